// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard unit with load-use stall, branch flush,
// forwarding select and saturating perf counters.
// Optional macro HAZARD_CTRL_FORWARDING_EN enables operand forwarding;
// without it every RAW dependence on EX/MEM/WB stalls until retired.
module hazard_ctrl #(
   parameter int ADDR_W = 5,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              arst_n,
   input  logic              enable,
   input  logic              id_valid,
   input  logic [ADDR_W-1:0] id_rs,
   input  logic [ADDR_W-1:0] id_rt,
   input  logic              id_uses_rt,
   input  logic              id_reg_write,
   input  logic              id_mem_read,
   input  logic [ADDR_W-1:0] id_waddr,
   input  logic              mem_take,
   output logic              pc_en,
   output logic              if_id_en,
   output logic              if_id_flush,
   output logic              id_ex_flush,
   output logic              ex_mem_flush,
   output logic [1:0]        fwd_a,
   output logic [1:0]        fwd_b,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   typedef struct packed {
      logic              valid;
      logic              reg_write;
      logic              mem_read;
      logic [ADDR_W-1:0] waddr;
      logic [ADDR_W-1:0] rs;
      logic [ADDR_W-1:0] rt;
   } shadow_t;

   localparam logic [1:0] SRC_RF  = 2'b00;
   localparam logic [1:0] SRC_WB  = 2'b01;
   localparam logic [1:0] SRC_MEM = 2'b10;

   shadow_t ex_q;
   shadow_t mem_q;
   shadow_t wb_q;
   shadow_t ex_d;
   shadow_t mem_d;
   shadow_t wb_d;
   shadow_t id_e;

   logic ex_wr;
   logic mem_wr;
   logic wb_wr;
   logic ex_hit;
   logic hazard;
   logic stall;
   logic stall_eff;
   logic unused_sink;

   // A shadow entry only produces a result if it is live and targets r1+
   function automatic logic is_writer(input shadow_t s);
      return s.valid & s.reg_write & (s.waddr != '0);
   endfunction

   // Does a shadow destination match an operand the ID instruction reads
   function automatic logic id_match(input shadow_t s);
      return (s.waddr == id_rs) | (id_uses_rt & (s.waddr == id_rt));
   endfunction

   assign ex_wr  = is_writer(ex_q);
   assign mem_wr = is_writer(mem_q);
   assign wb_wr  = is_writer(wb_q);
   assign ex_hit = id_match(ex_q);

`ifdef HAZARD_CTRL_FORWARDING_EN
   // Only a load in EX cannot be forwarded in time
   assign hazard = ex_wr & ex_q.mem_read & ex_hit;
`else
   logic mem_hit;
   logic wb_hit;

   assign mem_hit = id_match(mem_q);
   assign wb_hit  = id_match(wb_q);

   // No bypass: wait until the producer has left WB
   assign hazard = (ex_wr & ex_hit)
                 | (mem_wr & mem_hit)
                 | (wb_wr & wb_hit);
`endif

   assign stall     = id_valid & hazard;
   assign stall_eff = stall & ~mem_take;

   // Pack the ID-stage instruction into a shadow entry
   always_comb begin
      id_e           = '0;
      id_e.valid     = id_valid;
      id_e.reg_write = id_reg_write;
      id_e.mem_read  = id_mem_read;
      id_e.waddr     = id_waddr;
      id_e.rs        = id_rs;
      id_e.rt        = id_rt;
   end

   // Shadow pipeline next state: flush beats stall beats shift
   always_comb begin
      ex_d  = ex_q;
      mem_d = mem_q;
      wb_d  = wb_q;
      if (enable) begin
         if (mem_take) begin
            ex_d  = '0;
            mem_d = '0;
            wb_d  = mem_q;
         end else if (stall) begin
            ex_d  = '0;
            mem_d = ex_q;
            wb_d  = mem_q;
         end else begin
            ex_d  = id_e;
            mem_d = ex_q;
            wb_d  = mem_q;
         end
      end
   end

   // Shadow stage registers
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         ex_q  <= '0;
         mem_q <= '0;
         wb_q  <= '0;
      end else begin
         ex_q  <= ex_d;
         mem_q <= mem_d;
         wb_q  <= wb_d;
      end
   end

   // Saturating stall/flush counters, frozen while disabled
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else if (enable) begin
         if (mem_take && (flush_cnt != '1))
            flush_cnt <= flush_cnt + CNT_W'(1);
         if (stall_eff && (stall_cnt != '1))
            stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

   // Pipeline enables and bubble requests
   always_comb begin
      pc_en        = enable & ~stall_eff;
      if_id_en     = enable & ~stall_eff;
      if_id_flush  = mem_take;
      id_ex_flush  = mem_take | stall;
      ex_mem_flush = mem_take;
   end

`ifdef HAZARD_CTRL_FORWARDING_EN
   // Operand source select, youngest producer wins
   always_comb begin
      fwd_a = SRC_RF;
      fwd_b = SRC_RF;
      if (mem_wr && (mem_q.waddr == ex_q.rs))
         fwd_a = SRC_MEM;
      else if (wb_wr && (wb_q.waddr == ex_q.rs))
         fwd_a = SRC_WB;
      if (mem_wr && (mem_q.waddr == ex_q.rt))
         fwd_b = SRC_MEM;
      else if (wb_wr && (wb_q.waddr == ex_q.rt))
         fwd_b = SRC_WB;
   end
`else
   assign fwd_a = SRC_RF;
   assign fwd_b = SRC_RF;
`endif

   // Fields kept for visibility but not consumed in every build
   assign unused_sink = ^{ex_q, mem_q, wb_q, SRC_WB, SRC_MEM};

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed scenarios for hazard_ctrl.
// Expectations switch on HAZARD_CTRL_FORWARDING_EN where behaviour differs.
module tb_hazard_ctrl;

   logic       clk = 1'b0;
   logic       arst_n;
   logic       enable;
   logic       id_valid;
   logic [4:0] id_rs;
   logic [4:0] id_rt;
   logic       id_uses_rt;
   logic       id_reg_write;
   logic       id_mem_read;
   logic [4:0] id_waddr;
   logic       mem_take;

   logic        pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_flush;
   logic [1:0]  fwd_a, fwd_b;
   logic [31:0] stall_cnt, flush_cnt;

   logic        pc_en2, if_id_en2, if_id_flush2, id_ex_flush2, ex_mem_flush2;
   logic [1:0]  fwd_a2, fwd_b2;
   logic [1:0]  stall_cnt2, flush_cnt2;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   hazard_ctrl dut (
      .clk(clk), .arst_n(arst_n), .enable(enable),
      .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rt(id_uses_rt), .id_reg_write(id_reg_write),
      .id_mem_read(id_mem_read), .id_waddr(id_waddr),
      .mem_take(mem_take), .pc_en(pc_en), .if_id_en(if_id_en),
      .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
      .ex_mem_flush(ex_mem_flush), .fwd_a(fwd_a), .fwd_b(fwd_b),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   hazard_ctrl #(.ADDR_W(5), .CNT_W(2)) dut2 (
      .clk(clk), .arst_n(arst_n), .enable(enable),
      .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rt(id_uses_rt), .id_reg_write(id_reg_write),
      .id_mem_read(id_mem_read), .id_waddr(id_waddr),
      .mem_take(mem_take), .pc_en(pc_en2), .if_id_en(if_id_en2),
      .if_id_flush(if_id_flush2), .id_ex_flush(id_ex_flush2),
      .ex_mem_flush(ex_mem_flush2), .fwd_a(fwd_a2), .fwd_b(fwd_b2),
      .stall_cnt(stall_cnt2), .flush_cnt(flush_cnt2)
   );

   task automatic set_id(input logic v, input logic [4:0] rs,
                         input logic [4:0] rt, input logic urt,
                         input logic rw, input logic mr,
                         input logic [4:0] wa);
      id_valid     = v;
      id_rs        = rs;
      id_rt        = rt;
      id_uses_rt   = urt;
      id_reg_write = rw;
      id_mem_read  = mr;
      id_waddr     = wa;
   endtask

   task automatic idle();
      set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
   endtask

   task automatic reset_dut();
      arst_n   = 1'b0;
      enable   = 1'b1;
      mem_take = 1'b0;
      idle();
      @(negedge clk);
      @(negedge clk);
      arst_n = 1'b1;
   endtask

   task automatic test_reset();
      arst_n   = 1'b0;
      enable   = 1'b1;
      mem_take = 1'b0;
      set_id(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 5'd3);
      @(negedge clk); #1;
      checks++; if (pc_en !== 1'b1) begin errors++; $display("FAIL rst_pc_en got %b want 1", pc_en); end
      checks++; if (if_id_en !== 1'b1) begin errors++; $display("FAIL rst_if_id_en got %b want 1", if_id_en); end
      checks++; if ({fwd_a, fwd_b} !== 4'b0000) begin errors++; $display("FAIL rst_fwd got %b%b want 0000", fwd_a, fwd_b); end
      checks++; if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin errors++; $display("FAIL rst_cnt got %0d/%0d want 0/0", stall_cnt, flush_cnt); end
      checks++; if ({if_id_flush, id_ex_flush, ex_mem_flush} !== 3'b000) begin errors++; $display("FAIL rst_flush_idle got %b want 000", {if_id_flush, id_ex_flush, ex_mem_flush}); end
      mem_take = 1'b1;
      enable   = 1'b0;
      #1;
      checks++; if ({if_id_flush, id_ex_flush, ex_mem_flush} !== 3'b111) begin errors++; $display("FAIL rst_flush_take got %b want 111", {if_id_flush, id_ex_flush, ex_mem_flush}); end
      checks++; if (pc_en !== 1'b0 || if_id_en !== 1'b0) begin errors++; $display("FAIL rst_en_off got %b%b want 00", pc_en, if_id_en); end
      @(negedge clk); #1;
      checks++; if (flush_cnt !== 32'd0) begin errors++; $display("FAIL rst_flush_cnt got %0d want 0", flush_cnt); end
      reset_dut();
   endtask

   task automatic test_load_use();
      reset_dut();
      @(negedge clk);
      set_id(1'b1, 5'd1, 5'd0, 1'b0, 1'b1, 1'b1, 5'd3);
      #1;
      checks++; if (pc_en !== 1'b1) begin errors++; $display("FAIL lu_load_pc_en got %b want 1", pc_en); end
      @(negedge clk);
      set_id(1'b1, 5'd3, 5'd7, 1'b1, 1'b1, 1'b0, 5'd8);
      #1;
      checks++; if ({pc_en, if_id_en, id_ex_flush} !== 3'b001) begin errors++; $display("FAIL lu_stall got %b want 001", {pc_en, if_id_en, id_ex_flush}); end
      checks++; if ({if_id_flush, ex_mem_flush} !== 2'b00) begin errors++; $display("FAIL lu_no_flush got %b want 00", {if_id_flush, ex_mem_flush}); end
`ifdef HAZARD_CTRL_FORWARDING_EN
      @(negedge clk); #1;
      checks++; if (pc_en !== 1'b1 || stall_cnt !== 32'd1) begin errors++; $display("FAIL lu_release got pc_en=%b cnt=%0d want 1/1", pc_en, stall_cnt); end
      @(negedge clk);
      idle();
      #1;
      checks++; if (fwd_a !== 2'b01) begin errors++; $display("FAIL lu_fwd_a got %b want 01", fwd_a); end
`else
      @(negedge clk); #1;
      checks++; if (pc_en !== 1'b0) begin errors++; $display("FAIL lu_stall_mem got %b want 0", pc_en); end
      @(negedge clk); #1;
      checks++; if (pc_en !== 1'b0) begin errors++; $display("FAIL lu_stall_wb got %b want 0", pc_en); end
      @(negedge clk); #1;
      checks++; if (pc_en !== 1'b1 || stall_cnt !== 32'd3) begin errors++; $display("FAIL lu_release got pc_en=%b cnt=%0d want 1/3", pc_en, stall_cnt); end
      @(negedge clk);
      idle();
      #1;
      checks++; if (fwd_a !== 2'b00) begin errors++; $display("FAIL lu_fwd_a got %b want 00", fwd_a); end
`endif
   endtask

   task automatic test_alu_chain();
      reset_dut();
      @(negedge clk);
      set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd4);
      @(negedge clk);
      set_id(1'b1, 5'd4, 5'd4, 1'b1, 1'b1, 1'b0, 5'd9);
      #1;
`ifdef HAZARD_CTRL_FORWARDING_EN
      checks++; if (pc_en !== 1'b1) begin errors++; $display("FAIL alu_no_stall got %b want 1", pc_en); end
      @(negedge clk);
      set_id(1'b1, 5'd4, 5'd0, 1'b0, 1'b1, 1'b0, 5'd10);
      #1;
      checks++; if ({fwd_a, fwd_b} !== 4'b1010) begin errors++; $display("FAIL alu_fwd_mem got %b%b want 1010", fwd_a, fwd_b); end
      @(negedge clk);
      idle();
      #1;
      checks++; if ({fwd_a, fwd_b} !== 4'b0100) begin errors++; $display("FAIL alu_fwd_wb got %b%b want 0100", fwd_a, fwd_b); end
      checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL alu_stall_cnt got %0d want 0", stall_cnt); end
`else
      checks++; if (pc_en !== 1'b0) begin errors++; $display("FAIL alu_stall_ex got %b want 0", pc_en); end
      @(negedge clk); #1;
      checks++; if (if_id_en !== 1'b0) begin errors++; $display("FAIL alu_stall_mem got %b want 0", if_id_en); end
      @(negedge clk); #1;
      checks++; if (id_ex_flush !== 1'b1) begin errors++; $display("FAIL alu_stall_wb got %b want 1", id_ex_flush); end
      @(negedge clk); #1;
      checks++; if (pc_en !== 1'b1 || stall_cnt !== 32'd3) begin errors++; $display("FAIL alu_release got pc_en=%b cnt=%0d want 1/3", pc_en, stall_cnt); end
      @(negedge clk);
      idle();
      #1;
      checks++; if ({fwd_a, fwd_b} !== 4'b0000) begin errors++; $display("FAIL alu_fwd got %b%b want 0000", fwd_a, fwd_b); end
`endif
   endtask

   task automatic test_reg_zero();
      reset_dut();
      @(negedge clk);
      set_id(1'b1, 5'd1, 5'd0, 1'b0, 1'b1, 1'b1, 5'd0);
      @(negedge clk);
      set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 5'd2);
      #1;
      checks++; if (pc_en !== 1'b1) begin errors++; $display("FAIL r0_no_stall got %b want 1", pc_en); end
      @(negedge clk);
      set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd6);
      #1;
      checks++; if ({fwd_a, fwd_b} !== 4'b0000) begin errors++; $display("FAIL r0_fwd got %b%b want 0000", fwd_a, fwd_b); end
      @(negedge clk);
      set_id(1'b0, 5'd6, 5'd6, 1'b1, 1'b0, 1'b0, 5'd0);
      #1;
      checks++; if (pc_en !== 1'b1) begin errors++; $display("FAIL bubble_no_stall got %b want 1", pc_en); end
      set_id(1'b1, 5'd1, 5'd6, 1'b0, 1'b0, 1'b0, 5'd0);
      #1;
      checks++; if (pc_en !== 1'b1) begin errors++; $display("FAIL rt_unused got %b want 1", pc_en); end
      id_uses_rt = 1'b1;
      #1;
      checks++; if (pc_en !== 1'b0) begin errors++; $display("FAIL rt_used got %b want 0", pc_en); end
   endtask

   task automatic test_flush_priority();
      reset_dut();
      @(negedge clk);
      set_id(1'b1, 5'd1, 5'd0, 1'b0, 1'b1, 1'b1, 5'd3);
      @(negedge clk);
      set_id(1'b1, 5'd3, 5'd0, 1'b0, 1'b1, 1'b0, 5'd8);
      mem_take = 1'b1;
      #1;
      checks++; if ({if_id_flush, id_ex_flush, ex_mem_flush} !== 3'b111) begin errors++; $display("FAIL fp_flushes got %b want 111", {if_id_flush, id_ex_flush, ex_mem_flush}); end
      checks++; if ({pc_en, if_id_en} !== 2'b11) begin errors++; $display("FAIL fp_en got %b want 11", {pc_en, if_id_en}); end
      @(negedge clk);
      mem_take = 1'b0;
      idle();
      #1;
      checks++; if (flush_cnt !== 32'd1 || stall_cnt !== 32'd0) begin errors++; $display("FAIL fp_cnt got %0d/%0d want 1/0", flush_cnt, stall_cnt); end
      set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd5);
      @(negedge clk);
      idle();
      @(negedge clk);
      mem_take = 1'b1;
      @(negedge clk);
      mem_take = 1'b0;
      set_id(1'b1, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
      #1;
`ifdef HAZARD_CTRL_FORWARDING_EN
      checks++; if (pc_en !== 1'b1) begin errors++; $display("FAIL fp_wb_keep got %b want 1", pc_en); end
`else
      checks++; if (pc_en !== 1'b0) begin errors++; $display("FAIL fp_wb_keep got %b want 0", pc_en); end
`endif
      checks++; if (flush_cnt !== 32'd2) begin errors++; $display("FAIL fp_cnt2 got %0d want 2", flush_cnt); end
   endtask

   task automatic test_enable();
      reset_dut();
      @(negedge clk);
      enable   = 1'b0;
      mem_take = 1'b1;
      set_id(1'b1, 5'd1, 5'd0, 1'b0, 1'b1, 1'b1, 5'd3);
      #1;
      checks++; if ({pc_en, if_id_en} !== 2'b00) begin errors++; $display("FAIL en_off got %b want 00", {pc_en, if_id_en}); end
      checks++; if ({if_id_flush, ex_mem_flush} !== 2'b11) begin errors++; $display("FAIL en_off_flush got %b want 11", {if_id_flush, ex_mem_flush}); end
      @(negedge clk);
      enable   = 1'b1;
      mem_take = 1'b0;
      set_id(1'b1, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
      #1;
      checks++; if (pc_en !== 1'b1 || flush_cnt !== 32'd0) begin errors++; $display("FAIL en_hold got pc_en=%b fcnt=%0d want 1/0", pc_en, flush_cnt); end
      @(negedge clk);
      set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd3);
      @(negedge clk);
      enable = 1'b0;
      set_id(1'b1, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
      #1;
      checks++; if ({pc_en, id_ex_flush} !== 2'b01) begin errors++; $display("FAIL en_off_stall got %b want 01", {pc_en, id_ex_flush}); end
      @(negedge clk);
      enable = 1'b1;
      #1;
      checks++; if (pc_en !== 1'b0 || stall_cnt !== 32'd0) begin errors++; $display("FAIL en_frozen got pc_en=%b cnt=%0d want 0/0", pc_en, stall_cnt); end
   endtask

   task automatic test_saturation();
`ifdef HAZARD_CTRL_FORWARDING_EN
      int npair = 5;
      logic [31:0] exp_stalls = 32'd5;
`else
      int npair = 2;
      logic [31:0] exp_stalls = 32'd6;
`endif
      int guard;
      reset_dut();
      for (int p = 0; p < npair; p++) begin
         @(negedge clk);
         set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd3);
         @(negedge clk);
         set_id(1'b1, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
         #1;
         guard = 0;
         while (pc_en !== 1'b1 && guard < 10) begin
            @(negedge clk); #1;
            guard++;
         end
         checks++; if (guard >= 10) begin errors++; $display("FAIL sat_timeout got pc_en=%b want 1", pc_en); end
      end
      checks++; if (stall_cnt !== exp_stalls) begin errors++; $display("FAIL sat_wide got %0d want %0d", stall_cnt, exp_stalls); end
      checks++; if (stall_cnt2 !== 2'd3) begin errors++; $display("FAIL sat_narrow got %0d want 3", stall_cnt2); end
      @(negedge clk);
      idle();
      mem_take = 1'b1;
      repeat (4) @(negedge clk);
      mem_take = 1'b0;
      #1;
      checks++; if (flush_cnt !== 32'd4 || flush_cnt2 !== 2'd3) begin errors++; $display("FAIL sat_flush got %0d/%0d want 4/3", flush_cnt, flush_cnt2); end
      set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd3);
      @(negedge clk);
      set_id(1'b1, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
      #1;
      checks++; if (pc_en !== 1'b0) begin errors++; $display("FAIL mid_stall got %b want 0", pc_en); end
      arst_n = 1'b0;
      #1;
      checks++; if (stall_cnt !== 32'd0 || flush_cnt2 !== 2'd0) begin errors++; $display("FAIL mid_rst_cnt got %0d/%0d want 0/0", stall_cnt, flush_cnt2); end
      checks++; if ({pc_en, id_ex_flush} !== 2'b10) begin errors++; $display("FAIL mid_rst_en got %b want 10", {pc_en, id_ex_flush}); end
      @(negedge clk);
      arst_n = 1'b1;
      @(negedge clk); #1;
      checks++; if (pc_en !== 1'b1 || stall_cnt !== 32'd0) begin errors++; $display("FAIL post_rst got pc_en=%b cnt=%0d want 1/0", pc_en, stall_cnt); end
      idle();
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_alu_chain();
      test_reg_zero();
      test_flush_priority();
      test_enable();
      test_saturation();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
